// File: rtl/dreno_caixa.sv
// Outlet-side water tank controller: opens Valve_S on demand and tracks the level downward.
// Optional dry-run alarm register is built when DRAIN_DRY_ALARM_EN is defined.
module dreno_caixa #(
  parameter int LEVEL_W     = 3,
  parameter int STEP_CYCLES = 4,
  parameter int MIN_LEVEL   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               demand,
  input  logic               lower,
  input  logic               erro,
  input  logic               load,
  input  logic [LEVEL_W-1:0] level_in,
  output logic [LEVEL_W-1:0] count,
  output logic               Valve_S,
  output logic               empty,
  output logic               alarm
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] MIN_LVL   = LEVEL_W'(MIN_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    EMPTY = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [STEP_W-1:0]   step, step_nx;
  logic [LEVEL_W-1:0]  count_nx;
  logic [LEVEL_W-1:0]  count_dec;
  logic                load_ok;

  assign count_dec = count - 1'b1;

  // Priority on every edge: erro > lower > load > demand.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    count_nx = count;
    step_nx  = step;
    load_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (erro) begin
          state_nx = FAULT;
        end else if (lower) begin
          state_nx = EMPTY;
          count_nx = '0;
        end else if (load) begin
          count_nx = level_in;
          load_ok  = 1'b1;
        end else if (demand && (count > MIN_LVL)) begin
          state_nx = DRAIN;
          step_nx  = '0;
        end
      end
      DRAIN: begin
        if (erro) begin
          state_nx = FAULT;
          step_nx  = '0;
        end else if (lower) begin
          state_nx = EMPTY;
          count_nx = '0;
          step_nx  = '0;
        end else if (!demand) begin
          state_nx = IDLE;
          step_nx  = '0;
        end else if (step == STEP_LAST) begin
          // Reaching the reserve closes the valve on the same edge as the decrement.
          count_nx = count_dec;
          step_nx  = '0;
          if (count_dec == MIN_LVL) state_nx = IDLE;
        end else begin
          step_nx = step + 1'b1;
        end
      end
      EMPTY: begin
        if (erro) begin
          state_nx = FAULT;
        end else if (load && !lower) begin
          state_nx = IDLE;
          count_nx = level_in;
          load_ok  = 1'b1;
        end
      end
      FAULT: begin
        if (!erro) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they change only with state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      step    <= '0;
      Valve_S <= 1'b0;
      empty   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= state_nx;
      count   <= count_nx;
      step    <= step_nx;
      Valve_S <= (state_nx == DRAIN);
      empty   <= (state_nx == EMPTY);
    end
  end

`ifdef DRAIN_DRY_ALARM_EN
  logic alarm_q;

  // A fresh level from the inlet clears the dry-run condition; erro does not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (load_ok) begin
      alarm_q <= 1'b0;
    end else if ((state == EMPTY) && demand) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_load_ok;
  assign unused_load_ok = load_ok;
  assign alarm          = 1'b0;
`endif

endmodule

// File: tb/tb_dreno_caixa.sv
// Directed testbench for dreno_caixa: table of single-clock vectors plus hand-written sequences.
module tb_dreno_caixa;

  localparam int LW = 3;
`ifdef DRAIN_DRY_ALARM_EN
  localparam int ALARM_ON = 1;
`else
  localparam int ALARM_ON = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          demand, lower, erro, load;
  logic [LW-1:0] level_in;
  logic [LW-1:0] count;
  logic          Valve_S, empty, alarm;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dreno_caixa #(.LEVEL_W(LW), .STEP_CYCLES(4), .MIN_LEVEL(1)) dut (
    .clock   (clock),
    .reset   (reset),
    .demand  (demand),
    .lower   (lower),
    .erro    (erro),
    .load    (load),
    .level_in(level_in),
    .count   (count),
    .Valve_S (Valve_S),
    .empty   (empty),
    .alarm   (alarm)
  );

  typedef struct {
    logic          d, lw, e, ld;
    logic [LW-1:0] lvl;
    int            cnt;
    logic          v, em;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic d, input logic lw, input logic e, input logic ld,
                       input logic [LW-1:0] lvl);
    demand   = d;
    lower    = lw;
    erro     = e;
    load     = ld;
    level_in = lvl;
    tick();
  endtask

  task automatic do_reset();
    demand = 0; lower = 0; erro = 0; load = 0; level_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_out(input string name, input int c, input int v, input int em);
    check({name, ".count"}, int'(count), c);
    check({name, ".valve"}, int'(Valve_S), v);
    check({name, ".empty"}, int'(empty), em);
  endtask

  initial begin
    // Each entry is one clock: inputs, then expected count/valve/empty after the edge.
    tbl[0]  = '{0,0,0,1,3'd3, 3,0,0};  // load 3
    tbl[1]  = '{1,0,0,0,3'd0, 3,1,0};  // demand -> DRAIN
    tbl[2]  = '{1,0,0,0,3'd0, 3,1,0};
    tbl[3]  = '{1,0,0,0,3'd0, 3,1,0};
    tbl[4]  = '{1,0,0,0,3'd0, 3,1,0};
    tbl[5]  = '{1,0,0,0,3'd0, 2,1,0};  // first decrement
    tbl[6]  = '{1,0,0,0,3'd0, 2,1,0};
    tbl[7]  = '{1,0,0,0,3'd0, 2,1,0};
    tbl[8]  = '{1,0,0,0,3'd0, 2,1,0};
    tbl[9]  = '{1,0,0,0,3'd0, 1,0,0};  // reaches reserve, valve closes same edge
    tbl[10] = '{1,0,0,0,3'd0, 1,0,0};  // at reserve: no DRAIN
    tbl[11] = '{0,0,0,1,3'd1, 1,0,0};  // load level == MIN
    tbl[12] = '{1,0,0,0,3'd0, 1,0,0};
    tbl[13] = '{0,0,0,1,3'd0, 0,0,0};  // load 0, no clamp
    tbl[14] = '{0,1,0,0,3'd0, 0,0,1};  // lower -> EMPTY
    tbl[15] = '{0,1,0,1,3'd5, 0,0,1};  // load with lower still set: stay
    tbl[16] = '{0,0,0,1,3'd5, 5,0,0};  // accepted load -> IDLE
    tbl[17] = '{0,0,1,1,3'd2, 5,0,0};  // erro beats load
    tbl[18] = '{1,0,0,0,3'd0, 5,0,0};  // FAULT -> IDLE first
    tbl[19] = '{1,0,0,0,3'd0, 5,1,0};  // DRAIN
    tbl[20] = '{1,0,0,1,3'd2, 5,1,0};  // load ignored in DRAIN
    tbl[21] = '{1,1,1,0,3'd0, 5,0,0};  // erro + lower -> FAULT, count kept
    tbl[22] = '{0,0,0,0,3'd0, 5,0,0};
    tbl[23] = '{1,1,0,0,3'd0, 0,0,1};  // lower beats demand in IDLE

    // Reset state
    demand = 0; lower = 0; erro = 0; load = 0; level_in = '0;
    reset = 1'b1;
    #2;
    check_out("reset", 0, 0, 0);
    check("reset.alarm", int'(alarm), 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].d, tbl[i].lw, tbl[i].e, tbl[i].ld, tbl[i].lvl);
      check_out($sformatf("vec%0d", i), tbl[i].cnt, int'(tbl[i].v), int'(tbl[i].em));
    end

    // Asynchronous reset mid-DRAIN at count 5
    do_reset();
    drive(0, 0, 0, 1, 3'd6);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 3'd0);
    check_out("pre_rst", 5, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0);
    check("async_rst.alarm", int'(alarm), 0);
    tick();
    reset = 1'b0;

    // Full drain from 7: valve high exactly 24 clocks
    drive(0, 0, 0, 1, 3'd7);
    drive(1, 0, 0, 0, 3'd0);
    check_out("full.enter", 7, 1, 0);
    for (int i = 1; i <= 24; i++) begin
      drive(1, 0, 0, 0, 3'd0);
      check(    $sformatf("full%0d.count", i), int'(count), 7 - i / 4);
      check(    $sformatf("full%0d.valve", i), int'(Valve_S), (i < 24) ? 1 : 0);
    end
    drive(1, 0, 0, 0, 3'd0);
    check_out("full.after", 1, 0, 0);

    // Fault mid-drain, then re-demand restarts a full step
    do_reset();
    drive(0, 0, 0, 1, 3'd6);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 3'd0);
    check_out("flt.dec", 5, 1, 0);
    drive(1, 0, 0, 0, 3'd0);
    drive(1, 0, 0, 0, 3'd0);
    drive(1, 0, 1, 0, 3'd0);
    check_out("flt.erro", 5, 0, 0);
    drive(1, 0, 1, 0, 3'd0);
    check_out("flt.hold", 5, 0, 0);
    drive(0, 0, 0, 0, 3'd0);
    check_out("flt.idle", 5, 0, 0);
    drive(1, 0, 0, 0, 3'd0);
    check_out("flt.redrain", 5, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 3'd0);
      check(    $sformatf("flt.step%0d", i), int'(count), 5);
    end
    drive(1, 0, 0, 0, 3'd0);
    check_out("flt.dec2", 4, 1, 0);

    // Sensor empty during DRAIN at count 4, then reload
    drive(1, 1, 0, 0, 3'd0);
    check_out("sens.empty", 0, 0, 1);
    drive(0, 0, 0, 1, 3'd6);
    check_out("sens.reload", 6, 0, 0);

    // Dry-run alarm: set in EMPTY with demand, survives erro, cleared by load
    drive(0, 1, 0, 0, 3'd0);
    check_out("alm.empty", 0, 0, 1);
    check("alm.pre", int'(alarm), 0);
    drive(1, 1, 0, 0, 3'd0);
    check("alm.set", int'(alarm), ALARM_ON);
    drive(0, 0, 1, 0, 3'd0);
    check("alm.erro", int'(alarm), ALARM_ON);
    drive(0, 0, 0, 0, 3'd0);
    check("alm.idle", int'(alarm), ALARM_ON);
    drive(0, 0, 0, 1, 3'd3);
    check("alm.clear", int'(alarm), 0);
    check("alm.count", int'(count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
